// File: rtl/inv_edge_counter.sv
// Inverter ring edge counter: synchronizes a looped-back pad signal, counts
// its rising edges over a selectable gate window and exposes the latched
// result one byte at a time.
module inv_edge_counter #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sig_in,
    input  logic       start,
    input  logic [1:0] gate_sel,
    input  logic [1:0] byte_sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] count_byte
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_sync_dly;
    logic [1:0]               r_gate_sel;
    logic [13:0]              r_timer;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_ovf;
    logic [CNT_W-1:0]         r_result;
    logic                     r_result_ovf;
    logic                     r_busy;
    logic                     r_done;
    logic [7:0]               r_count_byte;

    logic                     w_edge;
    logic                     w_inc;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     w_ovf_nxt;
    logic [13:0]              w_gate_end;
    logic [23:0]              w_res_ext;

    assign busy       = r_busy;
    assign done       = r_done;
    assign count_byte = r_count_byte;

    // Synchronizer chain plus one delay flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_sync_dly <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_sync_dly <= r_sync[SYNC_STAGES-1];
        end
    end

    // Edge pulse, saturating next-count, and gate length decode
    always_comb begin
        w_edge    = r_sync[SYNC_STAGES-1] & ~r_sync_dly;
        w_inc     = (r_state == S_GATE) && w_edge;
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if (w_inc) begin
            if (&r_cnt) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
        case (r_gate_sel)
            2'd0:    w_gate_end = 14'd255;
            2'd1:    w_gate_end = 14'd1023;
            2'd2:    w_gate_end = 14'd4095;
            default: w_gate_end = 14'd16383;
        endcase
    end

    // Measurement FSM with counters, result latch and registered status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gate_sel   <= '0;
            r_timer      <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_result     <= '0;
            r_result_ovf <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && ena) begin
                        r_state    <= S_ARM;
                        r_gate_sel <= gate_sel;
                        r_cnt      <= '0;
                        r_timer    <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (!ena) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= S_GATE;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_timer <= '0;
                    end
                end
                S_GATE: begin
                    if (!ena) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= w_ovf_nxt;
                        // Result takes the post-increment value so an edge in
                        // the final gate cycle is still counted.
                        if (r_timer == w_gate_end) begin
                            r_state      <= S_DONE;
                            r_result     <= w_cnt_nxt;
                            r_result_ovf <= w_ovf_nxt;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 14'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Zero-extend the result so unused upper bytes read as zero
    always_comb begin
        w_res_ext              = '0;
        w_res_ext[CNT_W-1:0]   = r_result;
    end

    // Registered byte readout, valid in every state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count_byte <= '0;
        end else begin
            case (byte_sel)
                2'd0:    r_count_byte <= w_res_ext[7:0];
                2'd1:    r_count_byte <= w_res_ext[15:8];
                2'd2:    r_count_byte <= w_res_ext[23:16];
                default: r_count_byte <= {7'b0, r_result_ovf};
            endcase
        end
    end

endmodule

// File: tb/tb_inv_edge_counter.sv
// Directed bench for inv_edge_counter: a default-width instance and an
// 8-bit instance share the same stimulus.
module tb_inv_edge_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       sig_in;
    logic       start;
    logic [1:0] gate_sel;
    logic [1:0] byte_sel;
    logic       busy,  done;
    logic [7:0] cb;
    logic       busy8, done8;
    logic [7:0] cb8;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned phase    = 0;
    int          sig_mode = 4;

    always #5 clk = ~clk;

    inv_edge_counter #(.CNT_W(24), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in), .start(start),
        .gate_sel(gate_sel), .byte_sel(byte_sel),
        .busy(busy), .done(done), .count_byte(cb)
    );

    inv_edge_counter #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in), .start(start),
        .gate_sel(gate_sel), .byte_sel(byte_sel),
        .busy(busy8), .done(done8), .count_byte(cb8)
    );

    // Advance one clock; sig_in waveform: 0 low, 1 high, 2 period 8, 3 period 2, 4 random
    task automatic tick();
        @(posedge clk);
        #1;
        phase++;
        case (sig_mode)
            0:       sig_in = 1'b0;
            1:       sig_in = 1'b1;
            2:       sig_in = ((phase % 8) < 4);
            3:       sig_in = phase[0];
            default: sig_in = 1'($urandom_range(1, 0));
        endcase
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [7:0] obs,
                           input logic [7:0] lo, input logic [7:0] hi);
        n_checks++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h..%0h", tag, obs, lo, hi);
        end
    endtask

    // Pulse start, count busy cycles (bounded), optionally re-pulse start mid-gate
    task automatic run_gate(input string tag, input int exp_len, input int repulse_at);
        int n;
        n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            if (!busy) break;
            n++;
            if (repulse_at > 0 && n == repulse_at) begin
                start    = 1'b1;
                gate_sel = 2'd3;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk({tag, "_len"}, 16'(n), 16'(exp_len));
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
    endtask

    task automatic sel(input logic [1:0] s);
        byte_sel = s;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'($urandom_range(1, 0));
        start    = 1'($urandom_range(1, 0));
        gate_sel = 2'($urandom_range(3, 0));
        byte_sel = 2'($urandom_range(3, 0));
        sig_in   = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_busy", {15'd0, busy}, 16'd0);
            chk("rst_done", {15'd0, done}, 16'd0);
            chk("rst_cb", {8'd0, cb}, 16'd0);
            ena      = 1'($urandom_range(1, 0));
            start    = 1'($urandom_range(1, 0));
            gate_sel = 2'($urandom_range(3, 0));
            byte_sel = 2'($urandom_range(3, 0));
        end

        rst_n    = 1'b1;
        ena      = 1'b1;
        start    = 1'b0;
        gate_sel = 2'd0;
        byte_sel = 2'd0;
        sig_mode = 1;
        repeat (5) tick();
        chk("idle_busy", {15'd0, busy}, 16'd0);
        chk("idle_done", {15'd0, done}, 16'd0);

        // sig_in held high: no edges inside the gate
        run_gate("held", 257, 0);
        sel(2'd0); chk("held_b0", {8'd0, cb}, 16'h00);
        sel(2'd1); chk("held_b1", {8'd0, cb}, 16'h00);
        sel(2'd2); chk("held_b2", {8'd0, cb}, 16'h00);
        sel(2'd3); chk("held_ovf", {8'd0, cb}, 16'h00);
        repeat (3) tick();
        chk("done_hold", {15'd0, done}, 16'd1);

        // Period 8: about 32 edges in 256 cycles
        sig_mode = 2;
        repeat (8) tick();
        run_gate("p8", 257, 0);
        sel(2'd0); chk_rng("p8_b0", cb, 8'h1F, 8'h21);
        sel(2'd1); chk("p8_b1", {8'd0, cb}, 16'h00);
        sel(2'd2); chk("p8_b2", {8'd0, cb}, 16'h00);
        sel(2'd3); chk("p8_ovf", {8'd0, cb}, 16'h00);

        // Period 2, 1024-cycle gate: 8-bit instance saturates
        sig_mode = 3;
        gate_sel = 2'd1;
        run_gate("p2", 1025, 0);
        chk("p2_done8", {15'd0, done8}, 16'd1);
        sel(2'd0); chk("p2_b0_w8", {8'd0, cb8}, 16'hFF);
        sel(2'd3); chk("p2_ovf_w8", {8'd0, cb8}, 16'h01);
        chk("p2_ovf_w24", {8'd0, cb}, 16'h00);

        // sig_in low: overflow flag cleared by the new measurement
        sig_mode = 0;
        gate_sel = 2'd0;
        repeat (4) tick();
        run_gate("low", 257, 0);
        sel(2'd3); chk("low_ovf_w8", {8'd0, cb8}, 16'h00);
        sel(2'd0); chk("low_b0_w8", {8'd0, cb8}, 16'h00);

        // start re-pulsed mid-gate with a different gate_sel: ignored
        sig_mode = 2;
        repeat (8) tick();
        run_gate("repulse", 257, 100);
        gate_sel = 2'd0;
        sel(2'd0); chk_rng("repulse_b0", cb, 8'h1F, 8'h21);

        // ena dropped mid-gate: back to idle, previous result kept
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        chk("abort_busy_pre", {15'd0, busy}, 16'd1);
        ena = 1'b0;
        tick();
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_done", {15'd0, done}, 16'd0);
        start = 1'b1;
        repeat (3) tick();
        chk("ena_block", {15'd0, busy}, 16'd0);
        start = 1'b0;
        sel(2'd0); chk_rng("abort_b0", cb, 8'h1F, 8'h21);
        ena = 1'b1;

        // Reset mid-gate, then a clean measurement
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_busy", {15'd0, busy}, 16'd0);
        chk("mrst_done", {15'd0, done}, 16'd0);
        chk("mrst_cb", {8'd0, cb}, 16'h00);
        rst_n = 1'b1;
        tick();
        tick();
        chk("mrst_result", {8'd0, cb}, 16'h00);
        run_gate("post", 257, 0);
        sel(2'd0); chk_rng("post_b0", cb, 8'h1F, 8'h21);
        sel(2'd3); chk("post_ovf", {8'd0, cb}, 16'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/inv_edge_counter.md
INV_EDGE_COUNTER -- requirements
Module: inv_edge_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 24, meaning edge-count register width (8..24).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flop count on sig_in (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset: synchronous, active-low.
REQ-005 SHALL have port ena  input  1  block enable; low aborts a measurement.
REQ-006 SHALL have port sig_in  input  1  asynchronous digitized inverter output, looped back from a pad.
REQ-007 SHALL have port start  input  1  level, sampled each cycle; high in IDLE or DONE starts a measurement.
REQ-008 SHALL have port gate_sel  input  2  gate length select, sampled only on an accepted start.
REQ-009 SHALL have port byte_sel  input  2  readout byte select.
REQ-010 SHALL have port busy  output  1  high in ARM or GATE.
REQ-011 SHALL have port done  output  1  high in DONE.
REQ-012 SHALL have port count_byte  output  8  registered readout byte.

Function
REQ-013 SHALL pass sig_in through SYNC_STAGES flops, then one more flop; edge pulse = synced high and delayed low (rising edges only).
REQ-014 SHALL implement FSM states IDLE, ARM, GATE, DONE; reset state IDLE.
REQ-015 IDLE or DONE with start=1 and ena=1 SHALL go to ARM; gate_sel latched; edge counter and gate timer cleared; done cleared.
REQ-016 ARM SHALL last exactly one cycle, then go to GATE.
REQ-017 GATE SHALL last exactly G cycles: G = 256, 1024, 4096, 16384 for latched gate_sel 0, 1, 2, 3.
REQ-018 An edge pulse present during a GATE cycle SHALL increment the edge counter; pulses in other states SHALL be ignored.
REQ-019 Edge counter SHALL saturate at 2^CNT_W-1; an increment attempted at saturation SHALL set a sticky overflow flag, cleared only in ARM.
REQ-020 After the last GATE cycle, the FSM SHALL go to DONE and latch the counter and overflow into result/result_ovf in the same cycle.
REQ-021 done SHALL be 1 from the cycle after that last GATE cycle until the next accepted start or reset.
REQ-022 Latency: start accepted at cycle 0 -> ARM at cycle 1 -> GATE at cycles 2..G+1 -> done=1 at cycle G+2.
REQ-023 start in ARM or GATE SHALL be ignored; gate_sel changes after acceptance SHALL have no effect.
REQ-024 ena=0 in ARM or GATE SHALL return to IDLE next cycle; result and result_ovf keep their prior values; done=0.
REQ-025 ena=0 in IDLE or DONE SHALL block start; state is held.
REQ-026 count_byte SHALL register, each cycle: byte_sel 0 -> result[7:0], 1 -> result[15:8], 2 -> result[23:16], 3 -> {7'b0, result_ovf}; bits at or above CNT_W read 0.
REQ-027 count_byte SHALL update in all states, one cycle after byte_sel or result changes.

Reset
REQ-028 rst_n=0 at a clk edge SHALL force, in any state including mid-GATE: state IDLE, busy 0, done 0, count_byte 0x00, result 0, result_ovf 0, counters 0, synchronizer flops 0.
REQ-029 First edge with rst_n=1 SHALL begin normal operation; no edge SHALL be counted from the reset release itself.

Verification
REQ-030 Reset: rst_n low 3 cycles, random inputs -> busy=0, done=0, count_byte=0x00 each cycle.
REQ-031 sig_in held high, gate_sel=0, start pulse -> busy 257 cycles (ARM+GATE), done at cycle 258, all bytes 0x00, ovf byte 0x00.
REQ-032 sig_in period 8 clk (4 high/4 low), gate_sel=0 -> result 32 +/-1; byte_sel 0 reads 0x1F or 0x20 (0x21 permitted by the +/-1 bound); bytes 1-2 read 0x00.
REQ-033 CNT_W=8, sig_in period 2 clk, gate_sel=1 -> byte 0 = 0xFF, byte_sel 3 = 0x01; next start with sig_in low -> ovf byte 0x00.
REQ-034 start re-pulsed mid-GATE -> ignored, GATE length unchanged; ena dropped mid-GATE -> IDLE next cycle, done=0, previous result still readable.
REQ-035 rst_n low mid-GATE for 1 cycle -> IDLE, all outputs 0; subsequent start performs a full clean measurement.
